psum_buf: RTL

//  Row-organised partial-sum buffer directly downstream of a PEC. Serves the PEC's psum read port
//  (1-cycle latency) and write port. Accumulates one block of output rows; on block finish drains
//  the rows in address order over a valid/ready stream to the pooling/output stage, then self-clears.

---
 rtl/psum_buf.sv | 89 ++++++++
 1 files changed

// File: rtl/psum_buf.sv
// psum_buf: row partial-sum buffer with PEC read/write port and in-order drain stream.
// Optional PSB_RELU_EN clamps negative psums to zero on the drain output only.
module psum_buf #(
  parameter int PSUM_WIDTH = 23,
  parameter int LENPSUM    = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          PECRAM_EnWr,
  input  logic [ADDR_WIDTH-1:0]         PECRAM_AddrWr,
  input  logic [PSUM_WIDTH*LENPSUM-1:0] PECRAM_DatWr,
  input  logic                          PECRAM_EnRd,
  input  logic [ADDR_WIDTH-1:0]         PECRAM_AddrRd,
  output logic [PSUM_WIDTH*LENPSUM-1:0] RAMPEC_DatRd,
  input  logic                          PEBPSB_FnhBlk,
  output logic                          PSBPEC_Busy,
  output logic                          PSBPOL_Vld,
  input  logic                          PSBPOL_Rdy,
  output logic [PSUM_WIDTH*LENPSUM-1:0] PSBPOL_Dat,
  output logic                          PSBPOL_Lst,
  output logic                          PSBPOL_Err
);
  localparam int RW = PSUM_WIDTH*LENPSUM;
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic [1:0] {ACCUM, DRAIN, CLEAR} state_t;
  state_t                state;
  logic [RW-1:0]         mem [DEPTH];
  logic [DEPTH-1:0]      vld_bits;
  logic [CW-1:0]         hi_cnt, hi_nxt, wr_top;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  wr_ok, rd_ok, last;
  logic [RW-1:0]         raw;
  assign PSBPEC_Busy = state != ACCUM;
  assign PSBPOL_Vld  = state == DRAIN;
  assign wr_ok  = PECRAM_EnWr && !PSBPEC_Busy && int'(PECRAM_AddrWr) < DEPTH;
  assign rd_ok  = PECRAM_EnRd && !PSBPEC_Busy && int'(PECRAM_AddrRd) < DEPTH;
  assign wr_top = CW'(PECRAM_AddrWr) + CW'(1);
  assign hi_nxt = (wr_ok && wr_top > hi_cnt) ? wr_top : hi_cnt;
  assign last   = CW'(ptr) == hi_cnt - CW'(1);
  assign PSBPOL_Lst = PSBPOL_Vld && last;
  assign raw = vld_bits[ptr] ? mem[ptr] : '0;
`ifdef PSB_RELU_EN
  for (genvar i = 0; i < LENPSUM; i++) begin : g_relu
    assign PSBPOL_Dat[i*PSUM_WIDTH +: PSUM_WIDTH] =
      raw[(i+1)*PSUM_WIDTH-1] ? '0 : raw[i*PSUM_WIDTH +: PSUM_WIDTH];
  end
`else
  assign PSBPOL_Dat = raw;
`endif
  always_ff @(posedge clk)
    if (wr_ok) mem[PECRAM_AddrWr] <= PECRAM_DatWr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACCUM;
      vld_bits     <= '0;
      hi_cnt       <= '0;
      ptr          <= '0;
      RAMPEC_DatRd <= '0;
      PSBPOL_Err   <= 1'b0;
    end else begin
      if ((PECRAM_EnWr && !wr_ok) || (PECRAM_EnRd && !rd_ok)) PSBPOL_Err <= 1'b1;
      // write-first bypass so a same-cycle write to the read row is visible
      if (PECRAM_EnRd)
        RAMPEC_DatRd <= !rd_ok ? '0 :
                        (wr_ok && PECRAM_AddrWr == PECRAM_AddrRd) ? PECRAM_DatWr :
                        vld_bits[PECRAM_AddrRd] ? mem[PECRAM_AddrRd] : '0;
      case (state)
        ACCUM: begin
          if (wr_ok) vld_bits[PECRAM_AddrWr] <= 1'b1;
          hi_cnt <= hi_nxt;
          ptr    <= '0;
          if (PEBPSB_FnhBlk) state <= (hi_nxt == '0) ? CLEAR : DRAIN;
        end
        DRAIN:
          if (PSBPOL_Rdy) begin
            if (last) state <= CLEAR;
            else ptr <= ptr + 1'b1;
          end
        default: begin
          vld_bits <= '0;
          hi_cnt   <= '0;
          state    <= ACCUM;
        end
      endcase
    end
  end
endmodule
